// File: rtl/writeback_pc_update_pkg.sv
// Shared Y86-64 constants for the writeback/PC-update stage: instruction codes,
// register IDs, status codes and the commit FSM state type.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic {
    RUN     = 1'b0,
    STOPPED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_pc_update_if.sv
// Bundle between memory stage / decode and the writeback stage: the committed
// instruction fields plus decode's two register read ports.
interface writeback_pc_update_if #(parameter int n = 64);
  logic         commit;
  logic [3:0]   icode;
  logic         cnd;
  logic [3:0]   rA;
  logic [3:0]   rB;
  logic [n-1:0] valE;
  logic [n-1:0] valM;
  logic [n-1:0] valP;
  logic [n-1:0] valC;
  logic         imem_error;
  logic         instr_valid;
  logic         dmem_error;
  logic [3:0]   srcA;
  logic [3:0]   srcB;
  logic [n-1:0] valA;
  logic [n-1:0] valB;

  modport master (
    output commit, icode, cnd, rA, rB, valE, valM, valP, valC,
    output imem_error, instr_valid, dmem_error, srcA, srcB,
    input  valA, valB
  );

  modport slave (
    input  commit, icode, cnd, rA, rB, valE, valM, valP, valC,
    input  imem_error, instr_valid, dmem_error, srcA, srcB,
    output valA, valB
  );
endinterface

// File: rtl/writeback_pc_update_regfile.sv
// Architectural register file: NREG x n, two combinational read ports and two
// write ports (E and M); M wins when both target the same register.
module writeback_pc_update_regfile
  import y86_pkg::*;
#(
  parameter int n    = 64,
  parameter int NREG = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   dst_e,
  input  logic [n-1:0] val_e,
  input  logic [3:0]   dst_m,
  input  logic [n-1:0] val_m,
  input  logic [3:0]   src_a,
  input  logic [3:0]   src_b,
  output logic [n-1:0] val_a,
  output logic [n-1:0] val_b
);

  logic [n-1:0] regs_reg [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          regs_reg[gi] <= '0;
        end else if (dst_m == 4'(gi)) begin
          regs_reg[gi] <= val_m;
        end else if (dst_e == 4'(gi)) begin
          regs_reg[gi] <= val_e;
        end
      end
    end
  endgenerate

  // No bypass: a read in the write cycle returns the stored (old) value.
  always_comb begin
    val_a = '0;
    val_b = '0;
    if (32'(src_a) < NREG) val_a = regs_reg[src_a];
    if (32'(src_b) < NREG) val_b = regs_reg[src_b];
  end

endmodule

// File: rtl/writeback_pc_update.sv
// Y86-64 writeback stage: register writes, next-PC select, status and halt FSM.
// Optional RETIRE_CNT_EN adds a retired-instruction counter output.
module writeback_pc_update
  import y86_pkg::*;
#(
  parameter int           n        = 64,
  parameter logic [n-1:0] PC_RESET = '0,
  parameter int           NREG     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  writeback_pc_update_if.slave   wb,
  output logic [n-1:0]           pc,
  output logic [2:0]             stat,
  output logic                   halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [n-1:0]           retired
`endif
);

  wb_state_e    state_reg, state_next;
  logic [n-1:0] pc_reg, pc_next;
  logic [2:0]   stat_reg, stat_next;
  logic [2:0]   stat_eval;
  logic [3:0]   dst_e, dst_m;
  logic [3:0]   wr_dst_e, wr_dst_m;
  logic [n-1:0] pc_sel;
  logic         wr_en;
  logic         retire;

  always_comb begin
    stat_eval = SAOK;
    if (wb.imem_error || wb.dmem_error) stat_eval = SADR;
    else if (!wb.instr_valid)           stat_eval = SINS;
    else if (wb.icode == IHALT)         stat_eval = SHLT;
  end

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (wb.icode)
      IRRMOVQ:                    dst_e = wb.cnd ? wb.rB : RNONE;
      IIRMOVQ, IOPQ:              dst_e = wb.rB;
      ICALL, IRET, IPUSHQ, IPOPQ: dst_e = RRSP;
      default:                    dst_e = RNONE;
    endcase
    if (wb.icode == IMRMOVQ || wb.icode == IPOPQ) dst_m = wb.rA;
  end

  always_comb begin
    pc_sel = wb.valP;
    case (wb.icode)
      ICALL:   pc_sel = wb.valC;
      IJXX:    pc_sel = wb.cnd ? wb.valC : wb.valP;
      IRET:    pc_sel = wb.valM;
      default: pc_sel = wb.valP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      pc_reg    <= PC_RESET;
      stat_reg  <= SAOK;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      stat_reg  <= stat_next;
    end
  end

  // A faulting or halting instruction latches its status but leaves pc on its own address.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    stat_next  = stat_reg;
    wr_en      = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      RUN: begin
        if (wb.commit) begin
          stat_next = stat_eval;
          retire    = (stat_eval == SAOK) || (stat_eval == SHLT);
          if (stat_eval == SAOK) begin
            pc_next = pc_sel;
            wr_en   = 1'b1;
          end else begin
            state_next = STOPPED;
          end
        end
      end
      STOPPED: begin
        state_next = STOPPED;
      end
      default: state_next = RUN;
    endcase
  end

  assign wr_dst_e = wr_en ? dst_e : RNONE;
  assign wr_dst_m = wr_en ? dst_m : RNONE;

  writeback_pc_update_regfile #(
    .n    (n),
    .NREG (NREG)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .dst_e (wr_dst_e),
    .val_e (wb.valE),
    .dst_m (wr_dst_m),
    .val_m (wb.valM),
    .src_a (wb.srcA),
    .src_b (wb.srcB),
    .val_a (wb.valA),
    .val_b (wb.valB)
  );

  assign pc     = pc_reg;
  assign stat   = stat_reg;
  assign halted = (state_reg == STOPPED);

`ifdef RETIRE_CNT_EN
  logic [n-1:0] retired_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired_reg <= '0;
    else if (retire) retired_reg <= retired_reg + 1'b1;
  end

  assign retired = retired_reg;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule
